// File: rtl/config_packet_encoder.sv
// rtl/config_packet_encoder.sv - command FIFO plus packet formatter feeding a BFT leaf injection port
module config_packet_encoder #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int PAYLOAD_BITS  = 64,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_kind,
    input  logic [NUM_LEAF_BITS-1:0] cmd_leaf,
    input  logic [NUM_PORT_BITS-1:0] cmd_self_port,
    input  logic [NUM_LEAF_BITS-1:0] cmd_dst_src_leaf,
    input  logic [NUM_PORT_BITS-1:0] cmd_dst_src_port,
    input  logic [NUM_ADDR_BITS-1:0] cmd_bram_addr,
    input  logic [NUM_ADDR_BITS-1:0] cmd_freespace,
    output logic [PACKET_BITS-1:0]   o_packet,
    input  logic                     i_packet_ready,
    output logic [15:0]              o_pkt_count,
    output logic                     o_err,
    input  logic                     i_err_clr,
    output logic                     o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] KIND_OUT    = 2'd0;
    localparam logic [1:0] KIND_IN     = 2'd1;
    localparam logic [1:0] KIND_CREDIT = 2'd2;

    localparam logic [NUM_PORT_BITS-1:0] OUT_LO = NUM_PORT_BITS'(9);
    localparam logic [NUM_PORT_BITS-1:0] OUT_HI = NUM_PORT_BITS'(NUM_OUT_PORTS + 8);
    localparam logic [NUM_PORT_BITS-1:0] IN_LO  = NUM_PORT_BITS'(2);
    localparam logic [NUM_PORT_BITS-1:0] IN_HI  = NUM_PORT_BITS'(NUM_IN_PORTS + 1);

    // Payload field MSB positions, packed downward from the top of the payload
    localparam int P_SELF = PAYLOAD_BITS - 1;
    localparam int P_DLEAF = P_SELF - NUM_PORT_BITS;
    localparam int P_DPORT = P_DLEAF - NUM_LEAF_BITS;
    localparam int P_BRAM = P_DPORT - NUM_PORT_BITS;
    localparam int P_FREE = P_BRAM - NUM_ADDR_BITS;
    localparam int H_LEAF = PACKET_BITS - 2;
    localparam int H_PORT = H_LEAF - NUM_LEAF_BITS;

    typedef struct packed {
        logic [1:0]               kind;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] self_port;
        logic [NUM_LEAF_BITS-1:0] dst_src_leaf;
        logic [NUM_PORT_BITS-1:0] dst_src_port;
        logic [NUM_ADDR_BITS-1:0] bram_addr;
        logic [NUM_ADDR_BITS-1:0] freespace;
    } cmd_t;

    cmd_t                     mem [FIFO_DEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic                     ready_en;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     transfer;
    logic                     slot_free;
    cmd_t                     head;
    logic                     head_ok;
    logic [NUM_PORT_BITS-1:0] port_field;
    logic [PAYLOAD_BITS-1:0]  cfg_payload;
    logic [PAYLOAD_BITS-1:0]  payload;
    logic [PACKET_BITS-1:0]   head_pkt;
    logic                     out_range;
    logic                     in_range;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = ready_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign transfer  = o_packet[PACKET_BITS-1] && i_packet_ready;
    assign slot_free = !o_packet[PACKET_BITS-1] || transfer;
    assign pop       = slot_free && !empty;
    assign o_busy    = !empty || o_packet[PACKET_BITS-1];

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_range = (head.self_port >= OUT_LO) && (head.self_port <= OUT_HI);
    assign in_range  = (head.self_port >= IN_LO) && (head.self_port <= IN_HI);

    always_comb begin
        cfg_payload = '0;
        cfg_payload[P_SELF  -: NUM_PORT_BITS] = head.self_port;
        cfg_payload[P_DLEAF -: NUM_LEAF_BITS] = head.dst_src_leaf;
        cfg_payload[P_DPORT -: NUM_PORT_BITS] = head.dst_src_port;
        cfg_payload[P_BRAM  -: NUM_ADDR_BITS] = head.bram_addr;
        cfg_payload[P_FREE  -: NUM_ADDR_BITS] = head.freespace;
    end

    always_comb begin
        port_field = '0;
        payload    = '0;
        head_ok    = 1'b0;
        case (head.kind)
            KIND_OUT: begin
                payload = cfg_payload;
                head_ok = out_range;
            end
            KIND_IN: begin
                port_field = NUM_PORT_BITS'(1);
                payload    = cfg_payload;
                head_ok    = in_range;
            end
            KIND_CREDIT: begin
                port_field = head.self_port;
                payload    = PAYLOAD_BITS'(1);
                head_ok    = out_range;
            end
            default: head_ok = 1'b0;
        endcase
        head_pkt = '0;
        head_pkt[PACKET_BITS-1]            = 1'b1;
        head_pkt[H_LEAF -: NUM_LEAF_BITS]  = head.leaf;
        head_pkt[H_PORT -: NUM_PORT_BITS]  = port_field;
        head_pkt[PAYLOAD_BITS-1:0]         = payload;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{kind: cmd_kind, leaf: cmd_leaf, self_port: cmd_self_port,
                                     dst_src_leaf: cmd_dst_src_leaf, dst_src_port: cmd_dst_src_port,
                                     bram_addr: cmd_bram_addr, freespace: cmd_freespace};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ready_en    <= 1'b0;
            o_packet    <= '0;
            o_pkt_count <= '0;
            o_err       <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A dropped head leaves the slot empty rather than stalling the queue
            if (slot_free) begin
                o_packet <= (pop && head_ok) ? head_pkt : '0;
            end
            if (transfer) begin
                o_pkt_count <= o_pkt_count + 16'd1;
            end
            if (pop && !head_ok) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule
